serial_cmd_decoder: RTL

- Synthesizable front end for the VM command channel. Sits between the UART byte receiver and the command executor.
- Frames the incoming byte stream into commands: one opcode byte plus a fixed number of little-endian argument bytes, chosen per opcode.
- Presents each complete command as one valid/ready transaction downstream.
- Downstream-side backpressure stalls the byte stream.

---
 rtl/serial_cmd_decoder.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_cmd_decoder.sv
// -----------------------------------------------------------------------------
// serial_cmd_decoder
//
// Purpose:
//    Front end for the VM command channel. Frames the byte stream coming from
//    the UART receiver into commands: one opcode byte followed by a fixed
//    number of little-endian argument bytes selected by the opcode. Each
//    complete command is offered downstream as a single valid/ready
//    transaction. While a command is waiting to be taken, the byte stream is
//    stalled (rx_ready low).
//
//    Argument lengths: 'A' = 2, 'B' = 1, 'M' = 4, 'O' = 4, anything else = 0.
//    Opcodes with no argument (including unknown ones) are forwarded unchanged.
//
// Optional feature (macro SERIAL_CMD_TIMEOUT_EN):
//    When defined, a partially received command is aborted if TIMEOUT_CYCLES
//    clocks pass with no argument byte arriving; err_timeout pulses for one
//    cycle and the partial argument is discarded. When undefined, the
//    decoder waits indefinitely for argument bytes and err_timeout is 0.
//
// Parameters:
//    TIMEOUT_CYCLES  idle clocks allowed between argument bytes (timeout build)
//    TMO_W           width of the timeout counter, TIMEOUT_CYCLES < 2**TMO_W
//
// Ports:
//    clk          system clock, all state on rising edge
//    rst          asynchronous active-low reset (0 = reset)
//    rx_data      received byte from UART
//    rx_valid     rx_data valid
//    rx_ready     decoder accepts a byte this cycle
//    cmd          command opcode
//    arg          argument, first received byte in arg[7:0], unused bytes zero
//    arg_len      number of argument bytes collected (0, 1, 2 or 4)
//    cmd_valid    complete command available
//    cmd_ready    consumer takes the command
//    err_timeout  one-cycle pulse: partial command aborted
// -----------------------------------------------------------------------------
module serial_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TMO_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  cmd,
   output logic [31:0] arg,
   output logic [2:0]  arg_len,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        err_timeout
);

   // ---------------------------------------------------------------------
   // State encoding
   // ---------------------------------------------------------------------
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARG  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // ---------------------------------------------------------------------
   // Opcode to argument-length table
   // ---------------------------------------------------------------------
   function automatic logic [2:0] len_of(input logic [7:0] op);
      logic [2:0] len;
      case (op)
         8'h41:   len = 3'd2;   // 'A' 16-bit address
         8'h42:   len = 3'd1;   // 'B' bus data
         8'h4D:   len = 3'd4;   // 'M' control word
         8'h4F:   len = 3'd4;   // 'O' control word
         default: len = 3'd0;
      endcase
      return len;
   endfunction

   // ---------------------------------------------------------------------
   // Registers and next-state signals
   // ---------------------------------------------------------------------
   logic [1:0]  state_reg;
   logic [1:0]  state_next;
   logic        live_reg;        // low during reset, high from first clock after
   logic [7:0]  cmd_reg;
   logic [31:0] arg_reg;
   logic [31:0] arg_next;
   logic [2:0]  arg_len_reg;
   logic [2:0]  remaining_reg;
   logic [2:0]  remaining_next;
   logic [2:0]  count_reg;       // argument bytes already received
   logic [2:0]  count_next;

   logic [2:0]  op_len;
   logic        byte_xfer;
   logic        op_xfer;
   logic        arg_xfer;
   logic        last_arg;
   logic        cmd_xfer;
   logic        arg_clear;
   logic        tmo_expire;
   logic [3:0]  byte_we;

   // ---------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------
   // rx_ready is derived from registered state only; live_reg keeps it low
   // while reset is held even though the state register sits in IDLE.
   assign rx_ready  = live_reg && (state_reg != ST_HOLD);
   assign cmd_valid = (state_reg == ST_HOLD);

   assign op_len    = len_of(rx_data);
   assign byte_xfer = rx_valid && rx_ready;
   assign op_xfer   = byte_xfer && (state_reg == ST_IDLE);
   assign arg_xfer  = byte_xfer && (state_reg == ST_ARG);
   assign last_arg  = arg_xfer && (remaining_reg == 3'd1);
   assign cmd_xfer  = cmd_valid && cmd_ready;

   // A new opcode starts with a clean argument; an aborted one leaves none.
   assign arg_clear = op_xfer || tmo_expire;

   // ---------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (op_xfer) begin
               state_next = (op_len == 3'd0) ? ST_HOLD : ST_ARG;
            end
         end
         ST_ARG: begin
            // An arriving byte has priority over the timeout.
            if (last_arg) begin
               state_next = ST_HOLD;
            end else if (tmo_expire) begin
               state_next = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (cmd_xfer) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Byte bookkeeping
   // ---------------------------------------------------------------------
   always_comb begin
      remaining_next = remaining_reg;
      count_next     = count_reg;
      if (op_xfer) begin
         remaining_next = op_len;
         count_next     = 3'd0;
      end else if (arg_xfer) begin
         remaining_next = remaining_reg - 3'd1;
         count_next     = count_reg + 3'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Argument assembly, one lane per byte (little-endian order)
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_arg_lane
         assign byte_we[gi] = arg_xfer && (count_reg == 3'(gi));
         assign arg_next[8*gi +: 8] = arg_clear   ? 8'h00 :
                                      byte_we[gi] ? rx_data :
                                                    arg_reg[8*gi +: 8];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Main state registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         live_reg      <= 1'b0;
         cmd_reg       <= 8'h00;
         arg_reg       <= 32'h0000_0000;
         arg_len_reg   <= 3'd0;
         remaining_reg <= 3'd0;
         count_reg     <= 3'd0;
      end else begin
         state_reg     <= state_next;
         live_reg      <= 1'b1;
         arg_reg       <= arg_next;
         remaining_reg <= remaining_next;
         count_reg     <= count_next;
         if (op_xfer) begin
            cmd_reg     <= rx_data;
            arg_len_reg <= op_len;
         end
      end
   end

   assign cmd     = cmd_reg;
   assign arg     = arg_reg;
   assign arg_len = arg_len_reg;

   // ---------------------------------------------------------------------
   // Inter-byte timeout
   // ---------------------------------------------------------------------
`ifdef SERIAL_CMD_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_reg;
   logic             err_timeout_reg;

   // Expiry is detected on the idle cycle that would bring the count to
   // TIMEOUT_CYCLES, so the abort happens exactly TIMEOUT_CYCLES idle clocks
   // after the last accepted byte.
   assign tmo_expire = (state_reg == ST_ARG) && !arg_xfer && (tmo_cnt_reg == TMO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt_reg     <= '0;
         err_timeout_reg <= 1'b0;
      end else begin
         err_timeout_reg <= tmo_expire;
         if (op_xfer || arg_xfer || tmo_expire || (state_reg != ST_ARG)) begin
            tmo_cnt_reg <= '0;
         end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         end
      end
   end

   assign err_timeout = err_timeout_reg;
`else
   // Timeout hardware absent; the parameters only matter in the timeout build.
   logic [31:0] unused_tmo_cfg;
   assign unused_tmo_cfg = TIMEOUT_CYCLES + TMO_W;
   assign tmo_expire     = 1'b0;
   assign err_timeout    = 1'b0;
`endif

endmodule
